// File: rtl/tx_switch_if.sv
// Bundles the five outbound transaction channels and the link-side packet
// stream. The switch takes the slave view; the traffic source/link model
// takes the master view.
interface tx_switch_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int W = DATA_WIDTH * 8;

    logic [W-1:0] aw_din;
    logic         aw_last;
    logic         aw_valid;
    logic         aw_ready;
    logic [W-1:0] ar_din;
    logic         ar_valid;
    logic         ar_ready;
    logic [W-1:0] r_din;
    logic         r_last;
    logic         r_valid;
    logic         r_ready;
    logic [W-1:0] b_din;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] barrier_din;
    logic         barrier_valid;
    logic         barrier_ready;
    logic [W-1:0] tx_data;
    logic [3:0]   tx_connection_id;
    logic         tx_last;
    logic         tx_valid;
    logic         tx_ready;

    modport slave (
        input  aw_din, aw_last, aw_valid, ar_din, ar_valid,
               r_din, r_last, r_valid, b_din, b_valid,
               barrier_din, barrier_valid, tx_ready,
        output aw_ready, ar_ready, r_ready, b_ready, barrier_ready,
               tx_data, tx_connection_id, tx_last, tx_valid
    );

    modport master (
        output aw_din, aw_last, aw_valid, ar_din, ar_valid,
               r_din, r_last, r_valid, b_din, b_valid,
               barrier_din, barrier_valid, tx_ready,
        input  aw_ready, ar_ready, r_ready, b_ready, barrier_ready,
               tx_data, tx_connection_id, tx_last, tx_valid
    );
endinterface

// File: rtl/tx_switch.sv
// Transmit switch: round-robin merge of aw/ar/r/b/barrier into one packet
// stream. Header beats get their connection id moved to tx_connection_id and
// the packet type code written into bits [3:0]; multi-beat aw/r packets are
// kept contiguous by locking the grant until their last beat.
module tx_switch #(
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    tx_switch_if.slave  bus
);
    localparam int W = DATA_WIDTH * 8;

    typedef enum logic [1:0] {IDLE, AW_BURST, R_BURST} state_t;

    state_t       state;
    logic [2:0]   rr_ptr;
    logic [3:0]   id_reg;

    logic [4:0]   vld;
    logic [2:0]   grant;
    logic         grant_vld;
    logic         load_en;
    logic         accept;
    logic [W-1:0] sel_din;
    logic         sel_last;
    logic [W-1:0] enc_data;
    logic [3:0]   enc_id;

    assign vld     = {bus.barrier_valid, bus.b_valid, bus.r_valid, bus.ar_valid, bus.aw_valid};
    assign load_en = ~bus.tx_valid | bus.tx_ready;
    assign accept  = grant_vld & load_en;

    assign bus.aw_ready      = reset_n & load_en & (grant == 3'd0);
    assign bus.ar_ready      = reset_n & load_en & (grant == 3'd1);
    assign bus.r_ready       = reset_n & load_en & (grant == 3'd2);
    assign bus.b_ready       = reset_n & load_en & (grant == 3'd3);
    assign bus.barrier_ready = reset_n & load_en & (grant == 3'd4);

    // Grant: locked to the bursting channel, otherwise first valid at/after rr_ptr.
    // The scan runs backwards so the closest channel to rr_ptr wins.
    always_comb begin
        int         j;
        logic [2:0] idx;
        grant     = rr_ptr;
        grant_vld = 1'b0;
        j         = 0;
        idx       = 3'd0;
        case (state)
            AW_BURST: begin
                grant     = 3'd0;
                grant_vld = bus.aw_valid;
            end
            R_BURST: begin
                grant     = 3'd2;
                grant_vld = bus.r_valid;
            end
            default: begin
                for (int i = 4; i >= 0; i--) begin
                    j   = int'(rr_ptr) + i;
                    idx = (j >= 5) ? 3'(j - 5) : 3'(j);
                    if (vld[idx]) begin
                        grant     = idx;
                        grant_vld = 1'b1;
                    end
                end
            end
        endcase
    end

    // Beat select and header rewrite; burst data beats pass through untouched.
    always_comb begin
        sel_din  = bus.barrier_din;
        sel_last = 1'b1;
        case (grant)
            3'd0:    begin sel_din = bus.aw_din; sel_last = bus.aw_last; end
            3'd1:    begin sel_din = bus.ar_din; sel_last = 1'b1;        end
            3'd2:    begin sel_din = bus.r_din;  sel_last = bus.r_last;  end
            3'd3:    begin sel_din = bus.b_din;  sel_last = 1'b1;        end
            default: begin sel_din = bus.barrier_din; sel_last = 1'b1;   end
        endcase
        enc_data = sel_din;
        enc_id   = id_reg;
        if (state == IDLE) begin
            enc_id = sel_din[3:0];
            case (grant)
                3'd0:    enc_data = {sel_din[W-1:4], 4'h1};
                3'd1:    enc_data = {sel_din[W-1:4], 4'h2};
                3'd2:    enc_data = {sel_din[W-1:4], 4'h3};
                3'd3:    enc_data = {sel_din[W-1:4], 4'h4};
                default: enc_data = {sel_din[W-1:9], 1'b0, sel_din[7:4],
                                     (sel_din[8] ? 4'h5 : 4'h6)};
            endcase
        end
    end

    // Output register, burst FSM and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            rr_ptr               <= 3'd0;
            id_reg               <= 4'h0;
            bus.tx_valid         <= 1'b0;
            bus.tx_last          <= 1'b0;
            bus.tx_data          <= '0;
            bus.tx_connection_id <= 4'h0;
        end else if (accept) begin
            bus.tx_valid         <= 1'b1;
            bus.tx_data          <= enc_data;
            bus.tx_connection_id <= enc_id;
            bus.tx_last          <= sel_last;
            case (state)
                IDLE: begin
                    id_reg <= sel_din[3:0];
                    if (grant == 3'd0 && !bus.aw_last)
                        state <= AW_BURST;
                    else if (grant == 3'd2 && !bus.r_last)
                        state <= R_BURST;
                    else
                        rr_ptr <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
                end
                AW_BURST: begin
                    if (bus.aw_last) begin
                        state  <= IDLE;
                        rr_ptr <= 3'd1;
                    end
                end
                default: begin
                    if (bus.r_last) begin
                        state  <= IDLE;
                        rr_ptr <= 3'd3;
                    end
                end
            endcase
        end else if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
        end
    end
endmodule

// File: doc/tx_switch.md
Name: tx_switch

Overview:
- Transmit-side counterpart of the link receive switch.
- Merges the five outbound transaction channels (aw, ar, r, b, barrier) into one packet stream toward the link layer.
- Each channel's header beat carries its destination connection id in bits [3:0]. The block moves that id onto tx_connection_id, writes the packet type code into bits [3:0], and keeps multi-beat aw/r packets contiguous.
- Round-robin arbitration; one registered output stage.

Parameters:
DATA_WIDTH, 16, beat width in bytes (datapath is DATA_WIDTH*8 bits)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
aw_din  in  DATA_WIDTH*8  aw beat; on header beat [3:0] = connection id
aw_last  in  1  last beat of aw packet
aw_valid  in  1  aw beat valid
aw_ready  out  1  aw beat accepted
ar_din  in  DATA_WIDTH*8  ar header (single beat); [3:0] = connection id
ar_valid  in  1  ar valid
ar_ready  out  1  ar accepted
r_din  in  DATA_WIDTH*8  r beat; header [3:0] = connection id
r_last  in  1  last beat of r packet
r_valid  in  1  r valid
r_ready  out  1  r accepted
b_din  in  DATA_WIDTH*8  b header (single beat); [3:0] = connection id
b_valid  in  1  b valid
b_ready  out  1  b accepted
barrier_din  in  DATA_WIDTH*8  barrier (single beat); [3:0] id, [7:4] field, [8] kind
barrier_valid  in  1  barrier valid
barrier_ready  out  1  barrier accepted
tx_data  out  DATA_WIDTH*8  outbound beat
tx_connection_id  out  4  destination connection
tx_last  out  1  last beat of packet
tx_valid  out  1  outbound valid
tx_ready  in  1  link layer accepts beat

Behaviour:
- Reset (reset_n low, asynchronous): tx_valid=0, tx_last=0, tx_data=0, tx_connection_id=0, state=IDLE, rr pointer=aw. All *_ready are 0 while reset_n is low. A packet in flight at reset is dropped; there is no partial resume.
- Output stage: load_en = ~tx_valid | tx_ready. A beat is accepted from the granted channel when its valid is high and load_en is high. The beat appears on tx_* the next cycle (latency 1).
  - tx_valid clears when tx_ready is high and no new beat loads.
  - tx_* are stable while tx_valid=1 and tx_ready=0.
- *_ready = load_en & grant==channel & reset_n. Only the granted channel ever sees ready.
- Channel index: aw=0, ar=1, r=2, b=3, barrier=4.
- Header encoding (IDLE accepts only):
  - aw: tx_data={din[W-1:4],4'h1}
  - ar: tx_data={din[W-1:4],4'h2}
  - r: tx_data={din[W-1:4],4'h3}
  - b: tx_data={din[W-1:4],4'h4}
  - barrier: tx_data={din[W-1:9],1'b0,din[7:4],(din[8]?4'h5:4'h6)}
  - tx_connection_id=din[3:0], which is also latched into id_reg.
- States:
  - IDLE: grant = first valid channel at or after rr pointer, cyclic. A new grant may be made every cycle load_en is high.
    - aw accepted with aw_last=0 -> AW_BURST.
    - r accepted with r_last=0 -> R_BURST.
    - Otherwise stay in IDLE; rr pointer = granted+1 mod 5.
    - tx_last=1 for ar/b/barrier. For aw/r, tx_last equals the input last.
  - AW_BURST: grant locked to aw. Data beats pass unmodified (no type insertion); tx_connection_id=id_reg; tx_last=aw_last. On an accepted beat with aw_last=1 -> IDLE, rr pointer=1.
  - R_BURST: same as AW_BURST for r. On an accepted beat with r_last=1 -> IDLE, rr pointer=3.
- In a burst state, other channels' valids are ignored. The burst persists across aw/r valid gaps and tx_ready backpressure.
- A single-beat aw or r (last=1 on the header) stays in IDLE.
- Simultaneous valids: exactly one channel is accepted per cycle. No valid input is ever dropped or duplicated.

Test Plan:
- Reset with all valids high and reset_n=0 -> all *_ready=0, tx_valid=0. Release reset -> aw granted first, tx_data[3:0]=1, tx_valid seen one cycle after acceptance.
- ar_din=...A7 (id 7), tx_ready=1 -> tx_data[3:0]=2, tx_connection_id=7, tx_last=1, upper bits unchanged.
- aw packet of 3 beats (header id 5, last on beat 3) while b_valid is held high -> 3 contiguous aw beats, tx_connection_id=5 on all, beats 2-3 unmodified. The b beat follows the aw packet with tx_data[3:0]=4.
- barrier_din: [8]=1, [7:4]=0xC, id 2 -> tx_data[3:0]=5, [7:4]=0xC, [8]=0. With [8]=0 -> tx_data[3:0]=6.
- All five valids held for 10 single-beat packets -> grant order aw,ar,r,b,barrier,aw,... No starvation.
- r burst with tx_ready toggling 1/0 and r_valid gaps -> tx_* stable while stalled, no beat lost. reset_n pulsed low mid-burst -> tx_valid=0 immediately, state IDLE.
